// File: rtl/hstx_pkg.sv
// hstx_pkg: shared definitions for the HS-TX byte feeder slice.
//   tx_state_e    : state codes reported by the downstream HS-TX FSM
//   feed_state_e  : feeder burst-control states
//   ENTRY_W       : width of one FIFO entry ({last, data[7:0]})
//   fifo_entry_t  : packed view of a FIFO entry
package hstx_pkg;

  typedef enum logic [2:0] {
    TX_STOP  = 3'd0,
    TX_GO    = 3'd1,
    TX_SYNC  = 3'd2,
    TX_DATA  = 3'd3,
    TX_TRAIL = 3'd4
  } tx_state_e;

  typedef enum logic [1:0] {
    FEED_IDLE   = 2'd0,
    FEED_REQ    = 2'd1,
    FEED_STREAM = 2'd2,
    FEED_DRAIN  = 2'd3
  } feed_state_e;

  localparam int ENTRY_W = 9;

  typedef struct packed {
    logic       last;
    logic [7:0] data;
  } fifo_entry_t;

endpackage

// File: rtl/hstx_byte_feeder_if.sv
// hstx_byte_feeder_if: application-side and HS-TX-side signals of the feeder.
//   app_data/app_valid/app_last/app_ready : byte push handshake
//   TxState                               : HS-TX FSM state code
//   SOT/TxValid/TxByte_Data               : burst request and byte stream
//   underrun/underrun_clr                 : sticky underrun flag and its clear
//   pkt_sent_cnt                          : completed-burst counter (only with HSTX_PKT_CNT_EN)
// modport slave is the feeder's view, modport master the environment's view.
interface hstx_byte_feeder_if;

  logic [7:0]         app_data;
  logic               app_valid;
  logic               app_last;
  logic               app_ready;
  hstx_pkg::tx_state_e TxState;
  logic               SOT;
  logic               TxValid;
  logic [7:0]         TxByte_Data;
  logic               underrun;
  logic               underrun_clr;
`ifdef HSTX_PKT_CNT_EN
  logic [15:0]        pkt_sent_cnt;

  modport slave (
    input  app_data, app_valid, app_last, TxState, underrun_clr,
    output app_ready, SOT, TxValid, TxByte_Data, underrun, pkt_sent_cnt
  );

  modport master (
    output app_data, app_valid, app_last, TxState, underrun_clr,
    input  app_ready, SOT, TxValid, TxByte_Data, underrun, pkt_sent_cnt
  );
`else
  modport slave (
    input  app_data, app_valid, app_last, TxState, underrun_clr,
    output app_ready, SOT, TxValid, TxByte_Data, underrun
  );

  modport master (
    output app_data, app_valid, app_last, TxState, underrun_clr,
    input  app_ready, SOT, TxValid, TxByte_Data, underrun
  );
`endif

endinterface

// File: rtl/hstx_sync_fifo.sv
// hstx_sync_fifo: synchronous first-word-fall-through FIFO of {last, data} entries.
//   TxDDRClkHS : clock
//   TxRst      : synchronous active-high reset (empties the FIFO)
//   wr_en      : push request (ignored when full, even if a pop happens too)
//   wr_entry   : entry to push
//   rd_en      : pop request (ignored when empty)
//   head       : current head entry, valid whenever !empty
//   empty/full : derived from the registered occupancy
//   occupancy  : number of stored entries
//   last_cnt   : number of stored entries whose last bit is set
module hstx_sync_fifo
  import hstx_pkg::*;
#(
  parameter  int DEPTH = 16,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic        TxDDRClkHS,
  input  logic        TxRst,
  input  logic        wr_en,
  input  fifo_entry_t wr_entry,
  input  logic        rd_en,
  output fifo_entry_t head,
  output logic        empty,
  output logic        full,
  output logic [AW:0] occupancy,
  output logic [AW:0] last_cnt
);

  localparam logic [AW-1:0] PTR_ONE   = 1;
  localparam logic [AW:0]   CNT_ONE   = 1;
  localparam logic [AW:0]   CNT_DEPTH = (AW+1)'(DEPTH);

  fifo_entry_t   mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic          do_push;
  logic          do_pop;
  logic          last_in;
  logic          last_out;

  assign empty    = (occupancy == '0);
  assign full     = (occupancy == CNT_DEPTH);
  assign do_push  = wr_en && !full;
  assign do_pop   = rd_en && !empty;
  assign head     = mem[rptr];
  assign last_in  = do_push && wr_entry.last;
  assign last_out = do_pop && head.last;

  // NOTE: storage is deliberately not reset; the pointers and occupancy
  // decide which entries are meaningful, so stale contents are never seen.
  always_ff @(posedge TxDDRClkHS) begin
    if (do_push) begin
      mem[wptr] <= wr_entry;
    end
  end

  // NOTE: all sequential state uses non-blocking assignments so every
  // register samples the pre-edge values of the others.
  always_ff @(posedge TxDDRClkHS) begin
    if (TxRst) begin
      wptr      <= '0;
      rptr      <= '0;
      occupancy <= '0;
      last_cnt  <= '0;
    end else begin
      if (do_push) wptr <= wptr + PTR_ONE;
      if (do_pop)  rptr <= rptr + PTR_ONE;

      // Simultaneous push and pop leaves occupancy unchanged.
      if (do_push && !do_pop)      occupancy <= occupancy + CNT_ONE;
      else if (do_pop && !do_push) occupancy <= occupancy - CNT_ONE;

      if (last_in && !last_out)      last_cnt <= last_cnt + CNT_ONE;
      else if (last_out && !last_in) last_cnt <= last_cnt - CNT_ONE;
    end
  end

endmodule

// File: rtl/hstx_byte_feeder.sv
// hstx_byte_feeder: buffers application bytes and streams complete (or
// large enough) packets to the HS-TX FSM as gap-free bursts.
//   TxDDRClkHS : HS byte clock, the only clock
//   TxRst      : synchronous active-high reset
//   bus        : hstx_byte_feeder_if.slave (app push handshake, TxState,
//                SOT/TxValid/TxByte_Data, underrun/underrun_clr)
// Optional: define HSTX_PKT_CNT_EN to add bus.pkt_sent_cnt, a wrapping count
// of bursts that ended on a last byte.
module hstx_byte_feeder
  import hstx_pkg::*;
#(
  parameter int FIFO_DEPTH    = 16,
  parameter int START_THRESH  = 8,
  parameter int INTER_PKT_GAP = 4
) (
  input logic               TxDDRClkHS,
  input logic               TxRst,
  hstx_byte_feeder_if.slave bus
);

  localparam int            AW         = $clog2(FIFO_DEPTH);
  localparam logic [AW:0]   THRESH_CNT = (AW+1)'(START_THRESH);
  localparam logic [7:0]    GAP_LAST   = 8'(INTER_PKT_GAP - 1);

  feed_state_e state_q;
  feed_state_e state_d;
  logic [7:0]  gap_q;
  logic [7:0]  gap_d;
  logic        underrun_q;
  logic        underrun_set;
  logic        pop;
  logic        sot;
  logic        tx_valid;

  fifo_entry_t wr_entry;
  fifo_entry_t head;
  logic        empty;
  logic        full;
  logic [AW:0] occupancy;
  logic [AW:0] last_cnt;

  // Ready is forced low during reset so nothing is accepted into a FIFO
  // that is being emptied.
  assign bus.app_ready = !full && !TxRst;
  assign wr_entry      = '{last: bus.app_last, data: bus.app_data};

  hstx_sync_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .TxDDRClkHS (TxDDRClkHS),
    .TxRst      (TxRst),
    .wr_en      (bus.app_valid && bus.app_ready),
    .wr_entry   (wr_entry),
    .rd_en      (pop),
    .head       (head),
    .empty      (empty),
    .full       (full),
    .occupancy  (occupancy),
    .last_cnt   (last_cnt)
  );

  always_ff @(posedge TxDDRClkHS) begin
    if (TxRst) begin
      state_q <= FEED_IDLE;
      gap_q   <= '0;
    end else begin
      state_q <= state_d;
      gap_q   <= gap_d;
    end
  end

  // NOTE: every signal written here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d      = state_q;
    gap_d        = '0;
    pop          = 1'b0;
    sot          = 1'b0;
    tx_valid     = 1'b0;
    underrun_set = 1'b0;

    case (state_q)
      FEED_IDLE: begin
        if ((last_cnt != '0) || (occupancy >= THRESH_CNT)) begin
          state_d = FEED_REQ;
        end
      end

      FEED_REQ: begin
        sot      = 1'b1;
        tx_valid = 1'b1;
        if (bus.TxState == TX_DATA) begin
          pop = 1'b1;
          // A single-byte packet ends the burst right here; going to STREAM
          // would pull the next packet's head into this burst.
          state_d = head.last ? FEED_DRAIN : FEED_STREAM;
        end
      end

      FEED_STREAM: begin
        if (empty) begin
          // Ran dry before a last byte: no live byte this cycle.
          underrun_set = 1'b1;
          state_d      = FEED_DRAIN;
        end else begin
          sot      = 1'b1;
          tx_valid = 1'b1;
          pop      = 1'b1;
          if (head.last) state_d = FEED_DRAIN;
        end
      end

      FEED_DRAIN: begin
        // Counts only consecutive STOP cycles; any other code restarts it.
        if (bus.TxState == TX_STOP) begin
          if (gap_q == GAP_LAST) state_d = FEED_IDLE;
          else                   gap_d   = gap_q + 8'd1;
        end
      end

      default: state_d = FEED_IDLE;
    endcase
  end

  // Set has priority over clear so a detection is never lost.
  always_ff @(posedge TxDDRClkHS) begin
    if (TxRst)                 underrun_q <= 1'b0;
    else if (underrun_set)     underrun_q <= 1'b1;
    else if (bus.underrun_clr) underrun_q <= 1'b0;
  end

  assign bus.SOT         = sot;
  assign bus.TxValid     = tx_valid;
  assign bus.TxByte_Data = tx_valid ? head.data : 8'h00;
  assign bus.underrun    = underrun_q;

`ifdef HSTX_PKT_CNT_EN
  // Popping a last byte always ends a burst cleanly; underrun bursts never
  // pop a last byte, so they are not counted.
  logic [15:0] pkt_sent_q;

  always_ff @(posedge TxDDRClkHS) begin
    if (TxRst)                 pkt_sent_q <= '0;
    else if (pop && head.last) pkt_sent_q <= pkt_sent_q + 16'd1;
  end

  assign bus.pkt_sent_cnt = pkt_sent_q;
`endif

endmodule
